mux_nx1_rr: RTL and testbench
=============================

Name: mux_nx1_rr

Overview:
- Registered, parametrised N-input, WIDTH-bit multiplexer with a valid/ready handshake on every input channel and on the output.
- Two selection modes: fixed (external select) and round-robin (fair arbitration among valid channels).
- Sits in front of the ALU operand path, where several sources compete for one 32-bit operand bus.
- Successor to the 1-bit 2:1 mux: generalised in width and channel count, adds flow control and arbitration.

Parameters:
WIDTH, 32, data width per channel in bits
N, 4, number of input channels (2..16)
SELW, 2, width of the select and channel-index fields; must satisfy 2**SELW >= N

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready; combinational, at most one bit high
sel_mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel index used in fixed mode
out_data  output  WIDTH  registered output data
out_valid  output  1  registered output valid
out_ready  input  1  downstream ready
out_chan  output  SELW  registered index of the channel that produced out_data

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=0.
- Output stage: single register. load_en = !out_valid || out_ready. Full throughput is one word per cycle when out_ready is held high.
- Grant (combinational, evaluated only when load_en=1):
  - Fixed mode: grant channel sel if sel<N and in_valid[sel]=1; otherwise no grant.
  - Round-robin mode: grant the first i with in_valid[i]=1, scanning ptr, ptr+1, … mod N; no grant if all in_valid=0.
- in_ready[g] = load_en for the granted channel g; all other in_ready bits = 0. No grant means in_ready = 0.
- Transfer on an input occurs when in_valid[g] && in_ready[g]. At the next rising edge: out_data <= channel g data, out_chan <= g, out_valid <= 1.
- If load_en=1 and there is no grant: out_valid <= 0 at the next edge. out_data and out_chan hold their values.
- If out_valid=1 and out_ready=0 (stall): out_data, out_valid and out_chan hold; all in_ready = 0.
- Latency: input transfer at edge k gives out_valid=1 with that data after edge k (visible in cycle k+1).
- Pointer:
  - Updated only on a round-robin-mode transfer: ptr <= (g+1) mod N. Wrap from N-1 to 0 is required.
  - Fixed-mode transfers leave ptr unchanged.
  - ptr is retained across mode switches.
- Mode or sel changes take effect on the very next grant evaluation. A word already in the output register is unaffected.
- sel >= N (possible when N is not a power of 2): no grant, no transfer, no error flag.
- Inputs must hold data while valid and not ready. The block does not depend on this, since it samples only on transfer.
- Reset asserted mid-stall: output cleared immediately (asynchronously), and the pending word is dropped.

Test Plan:
1. Reset: rst_n=0 with all inputs toggling -> out_valid=0, out_data=0, out_chan=0, in_ready=0. Release; first cycle still out_valid=0.
2. Fixed mode, N=4, WIDTH=32: sel=2, in_valid=4'b1111, ch2=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=32'hDEADBEEF, out_chan=2, out_valid=1. sel=3 with in_valid[3]=0 -> in_ready=0, out_valid drops to 0 after one edge.
3. Round-robin fairness: all four valid, out_ready=1, ch i data = i+1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles; ptr wraps from 3 to 0.
4. Round-robin skip: ptr=1, in_valid=4'b1001 -> grant ch3, then ptr=0; next grant ch0, then ptr=1.
5. Backpressure: out_valid=1, out_ready=0 for 3 cycles with inputs valid -> out_data and out_chan stable, in_ready=0. Raise out_ready -> drained word replaced by a new word in the same cycle, no bubble.
6. Reset mid-stall: out_valid=1, out_ready=0, assert rst_n=0 between clock edges -> out_valid=0 immediately, ptr=0. After release with ch0 and ch2 valid in round-robin mode -> first grant is ch0.

Source files
------------

// File: rtl/mux_nx1_rr.sv
// Registered N:1 multiplexer with per-channel valid/ready handshakes.
// Channels are picked by an external select or by a round-robin pointer.
module mux_nx1_rr #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               sel_mode,
   input  logic [SELW-1:0]    sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_chan
);

   localparam int NPAD = 1 << SELW;
   localparam logic [SELW:0] N_W = (SELW+1)'(N);

   logic [WIDTH-1:0] chan_data [N];
   logic [NPAD-1:0]  valid_pad;
   logic             load_en;
   logic             gnt_valid;
   logic [SELW-1:0]  gnt_idx;
   logic             rr_valid;
   logic [SELW-1:0]  rr_idx;
   logic [SELW:0]    cand;
   logic [SELW:0]    inc;
   logic [SELW-1:0]  ptr_next;
   logic [WIDTH-1:0] mux_data;

   logic [WIDTH-1:0] out_data_reg;
   logic             out_valid_reg;
   logic [SELW-1:0]  out_chan_reg;
   logic [SELW-1:0]  ptr_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
         assign in_ready[gi]  = load_en & gnt_valid & (gnt_idx == SELW'(gi));
      end
   endgenerate

   // Padding lets an out-of-range select read a zero valid instead of indexing past N.
   always_comb begin
      valid_pad        = '0;
      valid_pad[N-1:0] = in_valid;
   end

   // Reset also gates ready so nothing handshakes while the output is held clear.
   assign load_en = rst_n & (~out_valid_reg | out_ready);

   // Scan from the farthest candidate back to ptr so the nearest valid channel wins.
   always_comb begin
      rr_valid = 1'b0;
      rr_idx   = '0;
      cand     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, ptr_reg} + (SELW+1)'(k);
         if (cand >= N_W) begin
            cand = cand - N_W;
         end
         if (valid_pad[cand[SELW-1:0]]) begin
            rr_valid = 1'b1;
            rr_idx   = cand[SELW-1:0];
         end
      end
   end

   always_comb begin
      if (sel_mode) begin
         gnt_valid = rr_valid;
         gnt_idx   = rr_idx;
      end else begin
         gnt_valid = valid_pad[sel];
         gnt_idx   = sel;
      end
   end

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SELW'(i)) begin
            mux_data = chan_data[i];
         end
      end
   end

   always_comb begin
      inc = {1'b0, gnt_idx} + (SELW+1)'(1);
      if (inc >= N_W) begin
         inc = '0;
      end
      ptr_next = inc[SELW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_chan_reg  <= '0;
         ptr_reg       <= '0;
      end else if (load_en) begin
         if (gnt_valid) begin
            out_data_reg  <= mux_data;
            out_chan_reg  <= gnt_idx;
            out_valid_reg <= 1'b1;
            if (sel_mode) begin
               ptr_reg <= ptr_next;
            end
         end else begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_chan  = out_chan_reg;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: directed vector table, reset corner cases and
// randomized traffic checked against a behavioural arbitration model.
module tb_mux_nx1_rr;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int SELW  = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic               sel_mode;
   logic [SELW-1:0]    sel;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SELW-1:0]    out_chan;

   mux_nx1_rr #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel_mode(sel_mode), .sel(sel),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_chan(out_chan)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference state: what the output register and the fairness pointer should hold.
   bit       m_valid;
   bit [31:0] m_data;
   int       m_chan;
   int       m_ptr;

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  vld;
      logic        ordy;
      logic [3:0]  rdy;
      logic        ov;
      logic [31:0] od;
      logic [1:0]  ch;
   } vec_t;

   vec_t tbl [18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] chan_word(input int i);
      return in_data[i*WIDTH +: WIDTH];
   endfunction

   // Which channel the spec says gets the grant this cycle (-1 = none).
   function automatic int model_grant();
      if (!rst_n) return -1;
      if (m_valid && !out_ready) return -1;
      if (!sel_mode) begin
         if (int'(sel) < N && in_valid[sel]) return int'(sel);
         return -1;
      end
      for (int k = 0; k < N; k++) begin
         if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_data  = 0;
      m_chan  = 0;
      m_ptr   = 0;
   endtask

   // Called just after inputs are driven at a falling edge; returns at the next falling edge.
   task automatic run_cycle(output logic [N-1:0] rdy_seen);
      int          g;
      bit          load;
      bit          mode_now;
      logic [31:0] d;
      logic [N-1:0] er;
      #1;
      g        = model_grant();
      load     = !m_valid || out_ready;
      mode_now = sel_mode;
      er       = (g >= 0) ? N'(1 << g) : '0;
      d        = (g >= 0) ? chan_word(g) : '0;
      rdy_seen = in_ready;
      check("in_ready", 64'(in_ready), 64'(er));
      @(posedge clk);
      if (load) begin
         if (g >= 0) begin
            m_valid = 1;
            m_data  = d;
            m_chan  = g;
            if (mode_now) m_ptr = (g + 1) % N;
         end else begin
            m_valid = 0;
         end
      end
      #1;
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_data", 64'(out_data), 64'(m_data));
      check("out_chan", 64'(out_chan), 64'(m_chan));
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] rdy;

      tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
      tbl[1]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2};
      tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h00000001, 2'd0};
      tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h00000002, 2'd1};
      tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
      tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'h00000004, 2'd3};
      tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h00000001, 2'd0};
      tbl[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 32'h00000004, 2'd3};
      tbl[8]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 32'h00000001, 2'd0};
      tbl[9]  = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 32'h00000002, 2'd1};
      tbl[10] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 32'h00000002, 2'd1};
      tbl[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'h00000002, 2'd1};
      tbl[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'h00000002, 2'd1};
      tbl[13] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 32'h00000002, 2'd1};
      tbl[14] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
      tbl[15] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2};
      tbl[16] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 32'h00000001, 2'd0};
      tbl[17] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 32'h00000001, 2'd0};

      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = '0;
      sel_mode  = 1'b0;
      sel       = '0;
      out_ready = 1'b0;
      model_reset();

      // Reset held with inputs toggling: everything stays cleared.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         in_valid  = N'($urandom);
         sel_mode  = 1'($urandom);
         sel       = SELW'($urandom);
         out_ready = 1'($urandom);
         #1;
         check("rst_in_ready", 64'(in_ready), 64'(0));
         check("rst_out_valid", 64'(out_valid), 64'(0));
         check("rst_out_data", 64'(out_data), 64'(0));
         check("rst_out_chan", 64'(out_chan), 64'(0));
         $display("reset cycle %0d: in_ready=%b out_valid=%b", c, in_ready, out_valid);
      end
      @(negedge clk);
      in_valid = '0;
      rst_n    = 1'b1;
      run_cycle(rdy);
      check("post_rst_out_valid", 64'(out_valid), 64'(0));

      in_data = {32'h00000004, 32'hDEADBEEF, 32'h00000002, 32'h00000001};
      for (int v = 0; v < 18; v++) begin
         sel_mode  = tbl[v].mode;
         sel       = tbl[v].sel;
         in_valid  = tbl[v].vld;
         out_ready = tbl[v].ordy;
         run_cycle(rdy);
         check($sformatf("vec%0d_in_ready", v), 64'(rdy), 64'(tbl[v].rdy));
         check($sformatf("vec%0d_out_valid", v), 64'(out_valid), 64'(tbl[v].ov));
         check($sformatf("vec%0d_out_data", v), 64'(out_data), 64'(tbl[v].od));
         check($sformatf("vec%0d_out_chan", v), 64'(out_chan), 64'(tbl[v].ch));
         $display("vec %0d: in_ready=%b out_valid=%b out_data=%h out_chan=%0d",
                  v, rdy, out_valid, out_data, out_chan);
      end

      // Reset between edges while the output is stalled.
      check("stall_before_rst", 64'(out_valid), 64'(1));
      sel_mode  = 1'b1;
      in_valid  = 4'b0101;
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'(0));
      check("async_rst_out_data", 64'(out_data), 64'(0));
      check("async_rst_out_chan", 64'(out_chan), 64'(0));
      check("async_rst_in_ready", 64'(in_ready), 64'(0));
      $display("mid-stall reset: out_valid=%b out_data=%h", out_valid, out_data);
      model_reset();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      run_cycle(rdy);
      check("rr_after_rst_chan", 64'(out_chan), 64'(0));
      check("rr_after_rst_data", 64'(out_data), 64'(32'h00000001));
      $display("after reset: grant=%b out_chan=%0d", rdy, out_chan);

      // Randomized traffic against the model.
      for (int t = 0; t < 400; t++) begin
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         in_valid  = N'($urandom);
         sel_mode  = 1'($urandom);
         sel       = SELW'($urandom_range(0, N - 1));
         out_ready = ($urandom_range(0, 3) != 0);
         run_cycle(rdy);
         $display("rand %0d: mode=%b sel=%0d valid=%b ordy=%b rdy=%b out_valid=%b out_chan=%0d out_data=%h",
                  t, sel_mode, sel, in_valid, out_ready, rdy, out_valid, out_chan, out_data);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
